// File: rtl/div_seq_if.sv
// -----------------------------------------------------------------------------
// div_seq_if
// Handshake/result bundle between CPU control and the iterative divider.
//
//   start  master->slave  request a division (sampled only while idle)
//   ai     master->slave  dividend, sampled with start
//   bi     master->slave  divisor, sampled with start
//   sgn    master->slave  signed-operation select (only with DIV_SIGNED_EN)
//   busy   slave->master  divider occupied (RUN and DONE)
//   done   slave->master  one-cycle result-valid pulse
//   quo    slave->master  quotient, held until the next accepted start
//   rem    slave->master  remainder, held until the next accepted start
//   dz     slave->master  divide-by-zero flag for the last operation
//
// Optional feature macro: DIV_SIGNED_EN (adds the sgn signal).
// -----------------------------------------------------------------------------
interface div_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dz;
`ifdef DIV_SIGNED_EN
    logic             sgn;

    modport master (output start, ai, bi, sgn, input busy, done, quo, rem, dz);
    modport slave  (input start, ai, bi, sgn, output busy, done, quo, rem, dz);
`else
    modport master (output start, ai, bi, input busy, done, quo, rem, dz);
    modport slave  (input start, ai, bi, output busy, done, quo, rem, dz);
`endif
endinterface

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Multi-cycle restoring divider, one quotient bit per clock. Feeds the ALU's
// divide result path; control raises start, stalls on busy, latches on done.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    div_seq_if.slave: start/ai/bi[/sgn] in, busy/done/quo/rem/dz out
//
// Latency: done is high WIDTH+1 cycles after start is accepted (1 cycle for
// a zero divisor). Both cases pass through RUN; the final RUN cycle with the
// counter at zero performs result write-back (and the sign fix-up).
//
// Optional feature macro: DIV_SIGNED_EN
//   Adds sgn: with sgn=1 operands are two's complement; magnitudes go through
//   the unsigned core and signs are restored on the edge entering DONE.
// -----------------------------------------------------------------------------
module div_seq #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    div_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prem_q, prem_d;     // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] bi_q, bi_d;         // divisor magnitude
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dzp_q, dzp_d;       // zero divisor seen for the running op
    logic             negq_q, negq_d;     // negate quotient at write-back
    logic             negr_q, negr_d;     // negate remainder at write-back
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic             sgn_act;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // Magnitude of a value that is two's complement when en is set.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic en);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        if (en && (s < 0))
            return $unsigned(-s);
        return v;
    endfunction

    // Conditional two's-complement negation used by the sign fix-up.
    function automatic logic [WIDTH-1:0] f_fix(input logic [WIDTH-1:0] v, input logic neg);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        if (neg)
            return $unsigned(-s);
        return v;
    endfunction

`ifdef DIV_SIGNED_EN
    assign sgn_act = bus.sgn;
`else
    assign sgn_act = 1'b0;
`endif

    assign a_mag = f_mag(bus.ai, sgn_act);
    assign b_mag = f_mag(bus.bi, sgn_act);

    // Restoring step: bring in the next dividend bit and try to subtract.
    // Extra top bit of trial is the borrow.
    assign shifted = {prem_q, dvd_q[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, bi_q};

    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        bi_d    = bi_q;
        cnt_d   = cnt_q;
        dzp_d   = dzp_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    if (bus.bi == '0) begin
                        // No iterations: the preset registers already hold
                        // the all-ones quotient and the raw dividend.
                        prem_d = bus.ai;
                        dvd_d  = '1;
                        bi_d   = '0;
                        cnt_d  = '0;
                        dzp_d  = 1'b1;
                        negq_d = 1'b0;
                        negr_d = 1'b0;
                    end else begin
                        prem_d = '0;
                        dvd_d  = a_mag;
                        bi_d   = b_mag;
                        cnt_d  = CW'(WIDTH);
                        dzp_d  = 1'b0;
                        dz_d   = 1'b0;
                        negq_d = sgn_act & (bus.ai[WIDTH-1] ^ bus.bi[WIDTH-1]);
                        negr_d = sgn_act & bus.ai[WIDTH-1];
                    end
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    if (!trial[WIDTH+1])
                        prem_d = WIDTH'(trial);
                    else
                        prem_d = WIDTH'(shifted);
                    dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH+1]};
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Write-back; most-negative / -1 wraps naturally since the
                    // magnitude quotient already equals the most-negative pattern.
                    state_d = DONE;
                    quo_d   = f_fix(dvd_q, negq_q);
                    rem_d   = f_fix(prem_q, negr_q);
                    dz_d    = dzp_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            prem_q  <= '0;
            dvd_q   <= '0;
            bi_q    <= '0;
            cnt_q   <= '0;
            dzp_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            bi_q    <= bi_d;
            cnt_q   <= cnt_d;
            dzp_q   <= dzp_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.quo  = quo_q;
    assign bus.rem  = rem_q;
    assign bus.dz   = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
// Self-checking bench for div_seq (WIDTH=8): directed cases plus randomized
// operands checked against an integer-arithmetic reference model.
// Optional feature macro: DIV_SIGNED_EN (enables the signed cases).
// -----------------------------------------------------------------------------
module tb_div_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; SV int division truncates toward zero
    // and the remainder keeps the sign of the dividend.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        int sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
            return;
        end
        z = 1'b0;
        if (!s) begin
            q = W'(int'(a) / int'(b));
            r = W'(int'(a) % int'(b));
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -(1 << (W - 1)) && sb == -1) begin
                q = a;
                r = '0;
            end else begin
                q = W'(sa / sb);
                r = W'(sa % sb);
            end
        end
    endfunction

    task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bus.start = st;
        bus.ai    = a;
        bus.bi    = b;
`ifdef DIV_SIGNED_EN
        bus.sgn   = s;
`else
        if (s) $display("note: signed request ignored in unsigned build");
`endif
    endtask

    // Waits (bounded) for done after an accepting edge; lat counts edges.
    task automatic wait_done(input string tag, output int lat);
        int busy_lo;
        busy_lo = 0;
        lat = 0;
        for (int c = 0; c < 4 * W; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy !== 1'b1) busy_lo++;
            if (bus.done === 1'b1) break;
        end
        chk({tag, "_busy_held"}, busy_lo, 0);
        if (bus.done !== 1'b1) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] eq, er;
        logic         ez;
        int           lat;
        ref_div(a, b, s, eq, er, ez);
        drive(1'b1, a, b, s);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, "_busy_on"}, bus.busy, 1);
        wait_done(tag, lat);
        chk({tag, "_lat"}, lat, (b == '0) ? 1 : W + 1);
        chk({tag, "_quo"}, bus.quo, eq);
        chk({tag, "_rem"}, bus.rem, er);
        chk({tag, "_dz"}, bus.dz, ez);
        @(posedge clk);
        #1;
        chk({tag, "_done_off"}, bus.done, 0);
        chk({tag, "_busy_off"}, bus.busy, 0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [W-1:0] ra, rb;
        logic         rs;

        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_quo", bus.quo, 0);
        chk("rst_rem", bus.rem, 0);
        chk("rst_dz", bus.dz, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op("d200_7", 8'd200, 8'd7, 1'b0);
        run_op("dz0D", 8'h0D, 8'h00, 1'b0);
        run_op("d9_3", 8'd9, 8'd3, 1'b0);
        run_op("d255_1", 8'd255, 8'd1, 1'b0);
        run_op("d3_5", 8'd3, 8'd5, 1'b0);

        // start held through RUN with changing operands
        drive(1'b1, 8'd100, 8'd9, 1'b0);
        @(posedge clk);
        #1;
        bus.ai = 8'd50;
        bus.bi = 8'd5;
        wait_done("hold", lat);
        chk("hold_lat", lat, W + 1);
        chk("hold_quo", bus.quo, 11);
        chk("hold_rem", bus.rem, 1);
        @(posedge clk);
        #1;
        chk("hold_idle_busy", bus.busy, 0);
        chk("hold_idle_done", bus.done, 0);
        @(posedge clk);
        #1;
        chk("hold_accept2", bus.busy, 1);
        bus.start = 1'b0;
        wait_done("hold2", lat);
        chk("hold2_lat", lat, W + 1);
        chk("hold2_quo", bus.quo, 10);
        chk("hold2_rem", bus.rem, 0);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of an operation
        drive(1'b1, 8'd100, 8'd9, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_quo", bus.quo, 0);
        chk("abort_rem", bus.rem, 0);
        chk("abort_dz", bus.dz, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 2 * W; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        run_op("d20_6", 8'd20, 8'd6, 1'b0);

`ifdef DIV_SIGNED_EN
        run_op("s_m7_2", 8'hF9, 8'd2, 1'b1);
        run_op("s_ovf", 8'h80, 8'hFF, 1'b1);
        run_op("s_dz", 8'hF9, 8'h00, 1'b1);
        run_op("u_F9_2", 8'hF9, 8'd2, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, (1 << W) - 1));
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 15));
`ifdef DIV_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op($sformatf("rnd%0d", i), ra, rb, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
